// File: rtl/shift_rotate_unit_pkg.sv
// Shared definitions for the shift/rotate unit: op and state encodings plus
// small decode helpers used by the unit and by the ALU control decoder.
package shift_pkg;

  // Mode encodings as driven on the op port.
  localparam logic [2:0] OP_ENC_SHR  = 3'b000;
  localparam logic [2:0] OP_ENC_SHRA = 3'b001;
  localparam logic [2:0] OP_ENC_SHL  = 3'b010;
  localparam logic [2:0] OP_ENC_ROR  = 3'b011;
  localparam logic [2:0] OP_ENC_ROL  = 3'b100;

  typedef enum logic [2:0] {
    OP_SHR  = OP_ENC_SHR,
    OP_SHRA = OP_ENC_SHRA,
    OP_SHL  = OP_ENC_SHL,
    OP_ROR  = OP_ENC_ROR,
    OP_ROL  = OP_ENC_ROL
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encodings above ROL are reserved and complete immediately as illegal.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_ENC_ROL;
  endfunction

  function automatic logic op_is_rotate(input logic [2:0] op);
    return (op == OP_ENC_ROR) || (op == OP_ENC_ROL);
  endfunction

endpackage

// File: rtl/shift_rotate_unit_step.sv
// Combinational single-step shifter: moves the working value by k (0..STEP)
// positions in the selected mode. Arithmetic fill uses the sign bit captured
// at start, not the current working value.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_value,
  input  op_t              i_op,
  input  logic [K_W-1:0]   i_k,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] w_sign_mask;

  // High-order positions vacated by a right shift of k.
  assign w_sign_mask = ~({WIDTH{1'b1}} >> i_k);

  // Select the per-mode shift of the working value.
  always_comb begin
    // NOTE: default assignment first so every path drives o_value and no latch is inferred.
    o_value = i_value;
    case (i_op)
      OP_SHR:  o_value = i_value >> i_k;
      OP_SHRA: o_value = (i_value >> i_k) | (i_sign ? w_sign_mask : '0);
      OP_SHL:  o_value = i_value << i_k;
      OP_ROR:  o_value = (i_value >> i_k) | (i_value << (WIDTH - int'(i_k)));
      OP_ROL:  o_value = (i_value << i_k) | (i_value >> (WIDTH - int'(i_k)));
      default: o_value = i_value;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit. A start in IDLE or DONE latches the operand,
// mode and effective count; RUN shifts up to STEP positions per clock until the
// count is exhausted, then DONE presents the result for one cycle.
module shift_rotate_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      amt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int K_W  = $clog2(STEP + 1);
  localparam int SH_W = $clog2(WIDTH);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_value;
  logic             r_sign;
  logic [AMT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;

  logic             w_legal;
  logic [AMT_W-1:0] w_n;
  logic [K_W-1:0]   w_k;
  logic [WIDTH-1:0] w_step;

  assign w_legal = op_is_legal(op);

  // Effective count: rotates wrap modulo WIDTH, shifts saturate at WIDTH
  // (judged on all 32 amount bits), illegal ops do no work.
  always_comb begin
    w_n = '0;
    if (!w_legal) begin
      w_n = '0;
    end else if (op_is_rotate(op)) begin
      w_n = {1'b0, amt[SH_W-1:0]};
    end else if (amt >= 32'(WIDTH)) begin
      w_n = AMT_W'(WIDTH);
    end else begin
      w_n = amt[AMT_W-1:0];
    end
  end

  // This clock's step size: a full STEP, or whatever remains.
  assign w_k = (r_count > AMT_W'(STEP)) ? K_W'(STEP) : r_count[K_W-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_value (r_value),
    .i_op    (r_op),
    .i_k     (w_k),
    .i_sign  (r_sign),
    .o_value (w_step)
  );

  // Control FSM with the working datapath and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      r_state   <= IDLE;
      r_op      <= OP_SHR;
      r_value   <= '0;
      r_sign    <= 1'b0;
      r_count   <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_value <= w_step;
          r_count <= r_count - AMT_W'(w_k);
          if (r_count == AMT_W'(w_k)) begin
            r_result  <= w_step;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; otherwise settle in IDLE.
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (w_n == '0) begin
              r_result  <= a;
              r_illegal <= !w_legal;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_value <= a;
              r_op    <= op_t'(op);
              r_sign  <= a[WIDTH-1];
              r_count <= w_n;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign result  = r_result;
  assign busy    = r_busy;
  assign done    = r_done;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit (WIDTH=32, STEP=4): directed cases
// followed by randomized operations compared against an arithmetic model.
module tb_shift_rotate_unit;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [2:0]        op;
  logic [WIDTH-1:0]  a;
  logic [31:0]       amt;
  logic [WIDTH-1:0]  result;
  logic              busy;
  logic              done;
  logic              illegal;

  int checks = 0;
  int errors = 0;

  logic [31:0] r_res;
  logic        r_ill;
  int          lat;
  int          bcnt;
  logic        seen;

  shift_rotate_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .a       (a),
    .amt     (amt),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: effective count straight from the mode rules.
  function automatic int ref_n(input logic [2:0] m_op, input logic [31:0] m_amt);
    if (m_op > 3'b100) return 0;
    if (m_op == 3'b011 || m_op == 3'b100) return int'(m_amt % 32);
    if (m_amt >= 32) return 32;
    return int'(m_amt);
  endfunction

  function automatic int ref_lat(input logic [2:0] m_op, input logic [31:0] m_amt);
    return (ref_n(m_op, m_amt) + STEP - 1) / STEP;
  endfunction

  // Reference: final value computed in one go with wide arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] m_op, input logic [31:0] m_a,
                                             input logic [31:0] m_amt);
    logic [63:0] dbl;
    int          r;
    dbl = {m_a, m_a};
    r   = int'(m_amt % 32);
    case (m_op)
      3'b000: return (m_amt >= 32) ? 32'h0 : (m_a >> m_amt);
      3'b001: return (m_amt >= 32) ? {32{m_a[31]}} : 32'($signed(m_a) >>> m_amt);
      3'b010: return (m_amt >= 32) ? 32'h0 : (m_a << m_amt);
      3'b011: begin dbl = dbl >> r; return dbl[31:0]; end
      3'b100: begin dbl = dbl << r; return dbl[63:32]; end
      default: return m_a;
    endcase
  endfunction

  // Wait (bounded) for done; counts cycles after the start edge and busy cycles.
  task automatic wait_done(output int o_lat, output int o_bcnt, output logic o_seen);
    o_lat  = 0;
    o_bcnt = 0;
    o_seen = 1'b0;
    @(negedge clk);
    while (!o_seen && o_lat < 200) begin
      if (done) begin
        o_seen = 1'b1;
      end else begin
        if (busy) o_bcnt++;
        o_lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_amt,
                        output logic [31:0] o_res, output logic o_ill, output int o_lat,
                        output int o_bcnt, output logic o_seen);
    @(negedge clk);
    op    = t_op;
    a     = t_a;
    amt   = t_amt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(o_lat, o_bcnt, o_seen);
    o_res = result;
    o_ill = illegal;
  endtask

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    amt   = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    @(negedge clk) clr = 1'b0;

    // ROR by 6: two steps, single-cycle done pulse.
    run_op(3'b011, 32'hC400_0000, 32'd6, r_res, r_ill, lat, bcnt, seen);
    check("t1_seen", seen, 1'b1);
    check("t1_result", r_res, 32'h0310_0000);
    check("t1_latency", lat, 2);
    check("t1_busy_cycles", bcnt, 2);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);

    // ROL by 1 and ROR by 33 (wraps to 1).
    run_op(3'b100, 32'h8000_0001, 32'd1, r_res, r_ill, lat, bcnt, seen);
    check("t2_rol_result", r_res, 32'h0000_0003);
    run_op(3'b011, 32'h0000_0001, 32'd33, r_res, r_ill, lat, bcnt, seen);
    check("t2_ror33_result", r_res, 32'h8000_0000);
    check("t2_ror33_latency", lat, 1);

    // Over-range shifts saturate at WIDTH.
    run_op(3'b001, 32'h8000_0000, 32'd40, r_res, r_ill, lat, bcnt, seen);
    check("t3_shra_result", r_res, 32'hFFFF_FFFF);
    check("t3_shra_latency", lat, 8);
    run_op(3'b000, 32'h8000_0000, 32'd40, r_res, r_ill, lat, bcnt, seen);
    check("t3_shr_result", r_res, 32'h0);

    // Zero amount and illegal op complete in the cycle after start.
    run_op(3'b010, 32'hFFFF_FFFF, 32'd0, r_res, r_ill, lat, bcnt, seen);
    check("t4_shl0_result", r_res, 32'hFFFF_FFFF);
    check("t4_shl0_latency", lat, 0);
    check("t4_shl0_busy", bcnt, 0);
    run_op(3'b111, 32'hA5A5_1234, 32'd5, r_res, r_ill, lat, bcnt, seen);
    check("t4_ill_result", r_res, 32'hA5A5_1234);
    check("t4_ill_flag", r_ill, 1'b1);
    check("t4_ill_latency", lat, 0);

    // Start during RUN is ignored; result holds until completion.
    @(negedge clk);
    op = 3'b011; a = 32'h1234_5678; amt = 32'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_result_held", result, 32'hA5A5_1234);
    op = 3'b010; a = 32'hFFFF_0000; amt = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt, seen);
    check("t5_seen", seen, 1'b1);
    check("t5_result", result, 32'h4567_8123);
    check("t5_illegal_cleared", illegal, 1'b0);
    // Back-to-back start in the DONE cycle.
    op = 3'b010; a = 32'h0000_0001; amt = 32'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt, seen);
    check("t5_b2b_result", result, 32'h0000_0100);
    check("t5_b2b_latency", lat, 2);

    // Asynchronous clear mid-RUN.
    run_op(3'b101, 32'h0000_00FF, 32'd0, r_res, r_ill, lat, bcnt, seen);
    check("t6_pre_illegal", r_ill, 1'b1);
    @(negedge clk);
    op = 3'b010; a = 32'h0000_FFFF; amt = 32'd31; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    #2 clr = 1'b1;
    #1;
    check("t6_clr_busy", busy, 1'b0);
    check("t6_clr_done", done, 1'b0);
    check("t6_clr_result", result, 32'h0);
    check("t6_clr_illegal", illegal, 1'b0);
    @(negedge clk) clr = 1'b0;
    run_op(3'b000, 32'h0000_00F0, 32'd4, r_res, r_ill, lat, bcnt, seen);
    check("t6_shr_result", r_res, 32'h0000_000F);
    check("t6_shr_latency", lat, 1);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  t_op;
      logic [31:0] t_a;
      logic [31:0] t_amt;
      t_op  = 3'($urandom_range(0, 7));
      t_a   = $urandom;
      t_amt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op(t_op, t_a, t_amt, r_res, r_ill, lat, bcnt, seen);
      check($sformatf("rnd%0d_seen", i), seen, 1'b1);
      check($sformatf("rnd%0d_result op=%0d a=%h amt=%0d", i, t_op, t_a, t_amt), r_res,
            ref_result(t_op, t_a, t_amt));
      check($sformatf("rnd%0d_illegal", i), r_ill, (t_op > 3'b100));
      check($sformatf("rnd%0d_latency", i), lat, ref_lat(t_op, t_amt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
Parametrised multi-cycle shift/rotate execution unit for the datapath ALU. It replaces the single-cycle fixed-32-bit rotate with a unit that supports five shift/rotate modes and a configurable word width. It shifts iteratively, at most STEP bit positions per clock, and uses a start/done handshake. Operands come from the A operand (Y register path) and the bus-supplied amount; the result goes to Z-low.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
STEP, 4, maximum bit positions shifted per clock; must be a power of two, 1 to WIDTH.
AMT_W, $clog2(WIDTH)+1, localparam; width of the internal remaining-count register.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled on a rising clk edge when the unit is not busy.
op  input  3  mode: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
a  input  WIDTH  operand to shift.
amt  input  32  shift amount, full register value, unsigned.
result  output  WIDTH  shifted value; held stable from done until the next accepted start.
busy  output  1  high while in RUN.
done  output  1  single-cycle pulse when result becomes valid.
illegal  output  1  registered with done; high if the completed op was illegal.

Behaviour:
- Reset (clr=1, any time, including mid-operation): state=IDLE, result=0, busy=0, done=0, illegal=0, count=0. The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted in IDLE or DONE at edge E. It latches a, op, and an effective count n. In RUN, start is ignored; it is not queued.
- Effective count n:
  - Rotates: n = amt mod WIDTH.
  - Shifts: n = min(amt, WIDTH), compared against all 32 bits of amt.
  - Illegal op: n = 0.
- Transitions:
  - From IDLE or DONE on an accepted start: go to DONE if n=0, otherwise RUN.
  - RUN: each edge shifts the working value by k = min(STEP, remaining) and subtracts k from remaining. When remaining reaches 0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE, unless a new start is accepted in that same cycle.
- Latency: S = ceil(n/STEP). done is high in the cycle following edge E+S. For n=0, done is high in the cycle after E.
- Per-step semantics:
  - SHR: fill with zeros.
  - SHRA: fill with bit WIDTH-1 of the operand latched at start.
  - SHL: zero-fill from the LSB.
  - ROR/ROL: bits wrap around the opposite end.
- Amount boundaries: shifts with amt >= WIDTH give 0 (SHR, SHL) or all copies of the sign bit (SHRA). amt = WIDTH on a rotate returns a unchanged with S=0.
- Illegal op: result = a, illegal=1, done after one cycle.
- result updates only when entering DONE. During RUN, result keeps its previous value.
- illegal is updated together with result and holds until the next completion.

Decomposition:
- Package shift_pkg holds:
  - op_t enum (SHR, SHRA, SHL, ROR, ROL);
  - state_t enum (IDLE, RUN, DONE);
  - the encoding constants, so the ALU control decoder and the bench share them.
- Sub-module shift_step: combinational single-step shifter. Inputs are the value, op, a k of 0..STEP, and the sign bit; output is the shifted value. It is parametrised by WIDTH and STEP and instantiated once.
- The FSM, count logic and registers live in shift_rotate_unit.

Test Plan:
1. ROR, a=0xC4000000, amt=6, WIDTH=32, STEP=4 -> result=0x03100000; done exactly 2 cycles after the start edge; busy high for 2 cycles.
2. ROL, a=0x80000001, amt=1 -> result=0x00000003. Then ROR, a=0x00000001, amt=33 -> n=1, result=0x80000000, S=1.
3. SHRA, a=0x80000000, amt=40 -> result=0xFFFFFFFF, S=8. Then SHR with the same inputs -> result=0x00000000.
4. SHL, a=0xFFFFFFFF, amt=0 -> result=0xFFFFFFFF, done in the cycle after start, busy never high. Then op=111 -> result=a, illegal=1.
5. Start ROR, a=0x12345678, amt=20; pulse start with different operands during RUN (ignored) -> result=0x45678123. Then assert start in the DONE cycle -> back-to-back operation accepted.
6. Assert clr asynchronously mid-RUN of SHL amt=31 -> busy, done, result and illegal go to 0 immediately. After clr deasserts, a new SHR, a=0xF0, amt=4 -> result=0x0000000F.
